thresholding_cfg_loader: RTL
============================

Name: thresholding_cfg_loader

Overview:
- Initiator for the threshold configuration port of the thresholding block; drives cfg_en/cfg_we/cfg_a/cfg_d and consumes cfg_rack/cfg_q.
- Write mode: takes a stream of threshold words and writes them into every channel's threshold slots in ascending order.
- Verify mode: re-streams the same words, issues readbacks and compares the returned data in order, reporting mismatches.
- Sits between a DMA or AXI-Stream parameter source and the thresholding instance, replacing host-driven AXI-Lite initialisation.

Parameters:
N, 4, output precision of the target; 2^N-1 thresholds per channel
K, 8, threshold width
C, 4, channel count
PE, 2, target PE count; C must be a multiple of PE, else $error at elaboration
RB_DEPTH, N+2, expected-value FIFO depth; must be at least the target readback latency (N) plus 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a pass when idle
mode  in  1  sampled with start: 0 = write, 1 = verify
s_tvalid  in  1  threshold stream valid
s_tready  out  1  threshold stream ready
s_tdata  in  K  threshold word
cfg_en  out  1  configuration op enable
cfg_we  out  1  1 = write, 0 = readback
cfg_a  out  $clog2(C/PE)+$clog2(PE)+N  configuration address
cfg_d  out  K  write data
cfg_rack  in  1  readback data valid
cfg_q  in  K  readback data
busy  out  1  pass in progress
done  out  1  one-cycle pulse at end of pass
err  out  1  sticky: verify mismatch or protocol error
err_cnt  out  16  saturating mismatch count
err_addr  out  width of cfg_a  address of first mismatch

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; cfg_en=0, cfg_we=0, cfg_a=0, cfg_d=0; s_tready=0; busy=0, done=0, err=0, err_cnt=0, err_addr=0; FIFO empty.
- Reset mid-pass aborts immediately, with no further cfg ops.
- FSM IDLE -> RUN on start: latches mode, clears err/err_cnt/err_addr, zeroes the counters.
- start while busy is ignored.
- RUN -> DRAIN after the last op issues; DRAIN -> IDLE when the FIFO is empty. In write mode DRAIN lasts 1 cycle.
- done pulses on the DRAIN -> IDLE transition cycle.
- busy = (state != IDLE).
- Issue order: channel c = 0..C-1 outer, index i = 0..2^N-2 inner. Slot 2^N-1 is never addressed. A pass totals C*(2^N-1) ops.
- Address fields: cfg_a[N-1:0] = i; next $clog2(PE) bits = c%PE; top $clog2(C/PE) bits = c/PE. Fields of width 0 are omitted.
- Outputs are registered: one stream beat accepted (s_tvalid && s_tready) at cycle t produces cfg_en=1 at cycle t+1 with its address and data.
  - Write mode: cfg_we=1, cfg_d=s_tdata.
  - Verify mode: cfg_we=0, cfg_d=0, and the beat is pushed into the expected FIFO.
- cfg_en=0 on any cycle without an accepted beat; bubbles are allowed.
- s_tready=1 only in RUN with ops remaining and, in verify mode, FIFO occupancy (counting a same-cycle pop) < RB_DEPTH.
- The target has no backpressure on cfg: every issued op is consumed.
- Readback is matched in order. On cfg_rack the FIFO is popped and cfg_q is compared with the head entry.
  - On mismatch, err=1 and err_cnt increments, saturating at 0xFFFF. err_addr is captured only on the first mismatch; the FIFO stores each entry's address alongside its value.
- cfg_rack with the FIFO empty, or in write mode, sets err and leaves err_cnt unchanged.
- A simultaneous push and pop leaves occupancy unchanged.
- Counter wrap: i at 2^N-2 wraps to 0 and c increments; the last op has c=C-1, i=2^N-2.
- Beats beyond C*(2^N-1) are not accepted (s_tready=0).

Test Plan:
- Write mode, N=2, K=8, C=4, PE=2, stream 0x01..0x0C with no gaps -> 12 writes on consecutive cycles. cfg_a sequence is 0,1,2,4,5,6,8,9,10,12,13,14; cfg_d follows the stream; done pulses once; err=0.
- Verify mode against a target model (latency N) preloaded with the above, re-streaming 0x01..0x0C -> 12 readbacks at the same addresses with cfg_we=0, err=0, done after the last cfg_rack.
- Verify with the model word at address 9 corrupted to 0xFF -> err=1, err_cnt=1, err_addr=9, done still pulses.
- RB_DEPTH=3 with model latency 6 -> s_tready deasserts after 3 outstanding ops, occupancy never exceeds 3, all 12 entries compared, err=0.
- s_tvalid toggling 1010... plus start asserted mid-pass -> cfg_en tracks accepted beats one cycle later, start is ignored, a second done does not appear.
- rst_n asserted after 5 writes -> all outputs are zero asynchronously. A subsequent start restarts at cfg_a=0.

Source files
------------

// File: rtl/thresholding_cfg_loader.sv
// Loads threshold words from a stream into every channel's threshold slots of a
// thresholding block, or reads them back and checks them against a re-stream.
module thresholding_cfg_loader #(
  parameter int N        = 4,
  parameter int K        = 8,
  parameter int C        = 4,
  parameter int PE       = 2,
  parameter int RB_DEPTH = N + 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  mode,
  input  logic                                  s_tvalid,
  output logic                                  s_tready,
  input  logic [K-1:0]                          s_tdata,
  output logic                                  cfg_en,
  output logic                                  cfg_we,
  output logic [$clog2(C/PE)+$clog2(PE)+N-1:0]  cfg_a,
  output logic [K-1:0]                          cfg_d,
  input  logic                                  cfg_rack,
  input  logic [K-1:0]                          cfg_q,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  output logic [15:0]                           err_cnt,
  output logic [$clog2(C/PE)+$clog2(PE)+N-1:0]  err_addr
);
  localparam int PEB  = $clog2(PE);
  localparam int GB   = $clog2(C / PE);
  localparam int AW   = GB + PEB + N;
  localparam int PEW  = (PEB > 0) ? PEB : 1;
  localparam int GW   = (GB > 0) ? GB : 1;
  localparam int PW   = (RB_DEPTH > 1) ? $clog2(RB_DEPTH) : 1;
  localparam int CW   = $clog2(RB_DEPTH + 1);
  localparam int EW   = AW + K;
  localparam int IMAX = (2 ** N) - 2;

  if ((C % PE) != 0) begin : g_pe_check
    $error("thresholding_cfg_loader: C must be a multiple of PE");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic              last_q, last_d;
  logic [N-1:0]      i_q, i_d;
  logic [PEW-1:0]    pe_q, pe_d;
  logic [GW-1:0]     grp_q, grp_d;
  logic              cfg_en_q, cfg_en_d;
  logic              cfg_we_q, cfg_we_d;
  logic [AW-1:0]     cfg_a_q, cfg_a_d;
  logic [K-1:0]      cfg_d_q, cfg_d_d;
  logic              err_q, err_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [AW-1:0]     err_addr_q, err_addr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [EW-1:0]     fifo_mem [RB_DEPTH];
  logic [AW-1:0]     addr, head_addr;
  logic [K-1:0]      head_data;
  logic              accept, push, pop;

  // Unused zero-valued fields simply OR in nothing when PE or C/PE is 1.
  assign addr = AW'(i_q) | (AW'(pe_q) << N) | (AW'(grp_q) << (N + PEB));
  assign {head_addr, head_data} = fifo_mem[rd_ptr_q];

  assign pop      = cfg_rack && (cnt_q != '0);
  assign s_tready = (state_q == RUN) && !last_q &&
                    (!mode_q || (cnt_q < CW'(RB_DEPTH)) || pop);
  assign accept   = s_tvalid && s_tready;
  assign push     = accept && mode_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    last_d     = last_q;
    i_d        = i_q;
    pe_d       = pe_q;
    grp_d      = grp_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    cfg_en_d   = accept;
    cfg_we_d   = accept && !mode_q;
    cfg_a_d    = accept ? addr : '0;
    cfg_d_d    = (accept && !mode_q) ? s_tdata : '0;

    if (push) wr_ptr_d = (wr_ptr_q == PW'(RB_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(RB_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

    // A readback nobody asked for is a protocol error, not a data mismatch.
    if (cfg_rack) begin
      if (!mode_q || (cnt_q == '0)) begin
        err_d = 1'b1;
      end else if (cfg_q != head_data) begin
        err_d = 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        if (err_cnt_q == 16'd0)    err_addr_d = head_addr;
      end
    end

    if (accept) begin
      if (i_q == N'(IMAX)) begin
        i_d = '0;
        if (pe_q == PEW'(PE - 1)) begin
          pe_d  = '0;
          grp_d = grp_q + GW'(1);
          if (grp_q == GW'(C / PE - 1)) last_d = 1'b1;
        end else begin
          pe_d = pe_q + PEW'(1);
        end
      end else begin
        i_d = i_q + N'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          mode_d     = mode;
          last_d     = 1'b0;
          i_d        = '0;
          pe_d       = '0;
          grp_d      = '0;
          err_d      = 1'b0;
          err_cnt_d  = '0;
          err_addr_d = '0;
        end
      end
      RUN:     if (last_q) state_d = DRAIN;
      DRAIN:   if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      last_q     <= 1'b0;
      i_q        <= '0;
      pe_q       <= '0;
      grp_q      <= '0;
      cfg_en_q   <= 1'b0;
      cfg_we_q   <= 1'b0;
      cfg_a_q    <= '0;
      cfg_d_q    <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      last_q     <= last_d;
      i_q        <= i_d;
      pe_q       <= pe_d;
      grp_q      <= grp_d;
      cfg_en_q   <= cfg_en_d;
      cfg_we_q   <= cfg_we_d;
      cfg_a_q    <= cfg_a_d;
      cfg_d_q    <= cfg_d_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Each expected entry carries its address so a mismatch can be located.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {addr, s_tdata};
  end

  assign cfg_en   = cfg_en_q;
  assign cfg_we   = cfg_we_q;
  assign cfg_a    = cfg_a_q;
  assign cfg_d    = cfg_d_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DRAIN) && (cnt_q == '0);
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;

endmodule
